// File: rtl/sm.sv
// Shared-memory common types: slot pointer and allocator response.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package sm;

    localparam int SM_PTR_WIDTH = 8;

    typedef logic [SM_PTR_WIDTH-1:0] sm_ptr_t;

    typedef enum logic {
        WR_OK           = 1'b0,
        WR_ERR_NO_SPACE = 1'b1
    } sm_code_t;

    typedef struct packed {
        sm_code_t code;
        sm_ptr_t  ptr;
    } sm_res_t;

endpackage

// File: rtl/sm_ptr_allocator.sv
// Shared-memory slot allocator: round-robin grants of free-list pointers, single free/CLEAR port.
// Latency: response (res_valid_o/res_o) exactly 1 cycle after the grant; 1 response per cycle.
// Backpressure: req_ready_o is a one-hot grant (none during INIT); free_ready_o high in RUN.
//
// Ports:
//   clk_i, rst_n_i      clock, async active-low reset
//   init_done_o         free-list loaded with 0..DEPTH-1
//   req_valid_i/_ready  per-requester allocation handshake
//   res_valid_o, res_o  one-hot owner + {code, ptr} response
//   free_valid_i/ptr_i  pointer returned to the pool; free_ready_o accepts it
//   free_cnt_o          free pointers held, 0..DEPTH
//   dbl_free_err_o      sticky double-free flag (only with SM_DOUBLE_FREE_CHECK_EN)
// Optional feature macro: SM_DOUBLE_FREE_CHECK_EN (allocated bitmap + double-free drop).
module sm_ptr_allocator #(
    parameter int NUM_REQ   = 4,
    parameter int PTR_WIDTH = sm::SM_PTR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    output logic                 init_done_o,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   res_valid_o,
    output sm::sm_res_t          res_o,
    input  logic                 free_valid_i,
    input  logic [PTR_WIDTH-1:0] free_ptr_i,
    output logic                 free_ready_o,
`ifdef SM_DOUBLE_FREE_CHECK_EN
    output logic                 dbl_free_err_o,
`endif
    output logic [PTR_WIDTH:0]   free_cnt_o
);

    localparam int DEPTH = 2 ** PTR_WIDTH;
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_WIDTH:0] FULL_CNT = {1'b1, {PTR_WIDTH{1'b0}}};
    localparam sm::sm_res_t RES_RST = '{code: sm::WR_OK, ptr: '0};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [PTR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0]   free_cnt_q, free_cnt_d;
    logic [RR_W-1:0]      rr_q, rr_d;
    logic [NUM_REQ-1:0]   res_valid_q, res_valid_d;
    sm::sm_res_t          res_q, res_d;

    // Free-list storage; contents are only meaningful between rd and wr index.
    logic [PTR_WIDTH-1:0] mem_q [DEPTH];
    logic                 mem_we;
    logic [PTR_WIDTH-1:0] mem_wa;
    logic [PTR_WIDTH-1:0] mem_wd;

    logic                 grant_any;
    logic [RR_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 pop_en;
    logic                 push_en;
    logic [PTR_WIDTH-1:0] pop_dat;

    function automatic logic [RR_W-1:0] rr_idx(input logic [RR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[RR_W-1:0];
    endfunction

    // Round-robin search starting at rr_q; first asserted requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (state_q == ST_RUN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_any && req_valid_i[rr_idx(rr_q, k)]) begin
                    grant_any = 1'b1;
                    grant_idx = rr_idx(rr_q, k);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign pop_en  = grant_any && (free_cnt_q != '0);

`ifdef SM_DOUBLE_FREE_CHECK_EN
    logic [DEPTH-1:0] alloc_map_q, alloc_map_d;
    logic             dbl_free_err_q, dbl_free_err_d;
    logic             free_seen;

    // The free is judged against the bitmap as it stood before this cycle's pop.
    assign free_seen = (state_q == ST_RUN) && free_valid_i;
    assign push_en   = free_seen && (free_cnt_q != FULL_CNT) && alloc_map_q[free_ptr_i];

    always_comb begin
        alloc_map_d    = alloc_map_q;
        dbl_free_err_d = dbl_free_err_q | (free_seen && !alloc_map_q[free_ptr_i]);
        if (push_en) alloc_map_d[free_ptr_i] = 1'b0;
        if (pop_en)  alloc_map_d[pop_dat]    = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            alloc_map_q    <= '0;
            dbl_free_err_q <= 1'b0;
        end else begin
            alloc_map_q    <= alloc_map_d;
            dbl_free_err_q <= dbl_free_err_d;
        end
    end

    assign dbl_free_err_o = dbl_free_err_q;
`else
    assign push_en = (state_q == ST_RUN) && free_valid_i && (free_cnt_q != FULL_CNT);
`endif

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        free_cnt_d  = free_cnt_q;
        rr_d        = rr_q;
        res_d       = res_q;
        res_valid_d = grant;
        mem_we      = 1'b0;
        mem_wa      = wr_ptr_q;
        mem_wd      = free_ptr_i;
        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_wd     = init_cnt_q;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                init_cnt_d = init_cnt_q + 1'b1;
                free_cnt_d = free_cnt_q + 1'b1;
                if (init_cnt_q == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (push_en) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (pop_en) rd_ptr_d = rd_ptr_q + 1'b1;
                case ({push_en, pop_en})
                    2'b10:   free_cnt_d = free_cnt_q + 1'b1;
                    2'b01:   free_cnt_d = free_cnt_q - 1'b1;
                    default: free_cnt_d = free_cnt_q;
                endcase
                if (grant_any) begin
                    rr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                    if (pop_en) begin
                        res_d.code = sm::WR_OK;
                        res_d.ptr  = sm::sm_ptr_t'(pop_dat);
                    end else begin
                        res_d.code = sm::WR_ERR_NO_SPACE;
                        res_d.ptr  = '0;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            free_cnt_q  <= '0;
            rr_q        <= '0;
            res_valid_q <= '0;
            res_q       <= RES_RST;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            free_cnt_q  <= free_cnt_d;
            rr_q        <= rr_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    assign init_done_o  = (state_q == ST_RUN);
    assign free_ready_o = (state_q == ST_RUN);
    assign req_ready_o  = grant;
    assign res_valid_o  = res_valid_q;
    assign res_o        = res_q;
    assign free_cnt_o   = free_cnt_q;

endmodule

// File: doc/sm_ptr_allocator.md
Name: sm_ptr_allocator

Overview:
- Owns the shared-memory slot pool.
- Grants slot pointers (sm::sm_ptr_t) to NUM_REQ write requesters using round-robin arbitration.
- Each grant returns an sm::sm_res_t: WR_OK with a pointer, or WR_ERR_NO_SPACE.
- Reclaims slots through a single CLEAR/free port.
- Sits between the write clients and the shared-memory data RAM.
- Free pointers are held in an internal circular free-list, filled by an init sequence after reset.

Parameters:
NUM_REQ, 4, number of allocation requesters (1..16)
PTR_WIDTH, sm::SM_PTR_WIDTH (8), pointer width; pool depth DEPTH = 2**PTR_WIDTH (localparam, 256)

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
init_done_o  output  1  high once the free-list is fully initialised
req_valid_i  input  NUM_REQ  per-requester allocation request, held until ready
req_ready_o  output  NUM_REQ  one-hot grant; request consumed when valid&ready
res_valid_o  output  NUM_REQ  one-hot, one cycle after the grant, marks the owner of res_o
res_o  output  $bits(sm::sm_res_t)  sm::sm_res_t response {code, ptr}
free_valid_i  input  1  CLEAR request for free_ptr_i
free_ptr_i  input  PTR_WIDTH  pointer being returned to the pool
free_ready_o  output  1  free port ready
free_cnt_o  output  PTR_WIDTH+1  number of free pointers, 0..DEPTH

Behaviour:
- Reset values (async, rst_n_i low):
  - State = INIT; init counter 0.
  - Free-list rd/wr pointers 0; free_cnt_o 0.
  - init_done_o, req_ready_o, res_valid_o, free_ready_o all 0.
  - res_o = {WR_OK, 0}.
  - RR priority pointer = requester 0.
- Reset asserted mid-operation aborts everything, with no response for in-flight grants. On release, INIT restarts.
- INIT state:
  - Each cycle writes the init counter value into the free-list and increments free_cnt_o.
  - After DEPTH cycles (pointers 0..DEPTH-1 loaded): go to RUN, set init_done_o=1, free_cnt_o=DEPTH.
  - All request and free inputs are ignored during INIT.
- RUN state: stays in RUN until reset.
- Arbitration (combinational from registered state):
  - Among asserted req_valid_i, grant the first index at or after the RR pointer, wrapping modulo NUM_REQ.
  - At most one grant per cycle; req_ready_o is 0 for non-granted requesters.
  - After any grant to i, RR pointer becomes (i+1) mod NUM_REQ.
  - No grant leaves the RR pointer unchanged.
- Allocation:
  - Granted with free_cnt>0: pop the free-list head. Next cycle: res_o={WR_OK, popped ptr}, res_valid_o[i]=1.
  - Granted with free_cnt==0: no pop. Next cycle: res_o={WR_ERR_NO_SPACE, 0}, res_valid_o[i]=1.
  - Latency is exactly 1 cycle. Throughput is 1 response per cycle.
  - res_valid_o is a single-cycle pulse. res_o holds its last value when not valid.
- Free:
  - free_ready_o=1 in RUN.
  - free_valid_i&free_ready_o pushes free_ptr_i at the tail and increments free_cnt.
  - If free_cnt==DEPTH, the free is dropped; count and list are unchanged.
- Simultaneous alloc and free in the same cycle:
  - Both are performed; free_cnt is unchanged.
  - If free_cnt==0 at that edge, the alloc still returns WR_ERR_NO_SPACE (no same-cycle bypass). The freed pointer is stored and free_cnt becomes 1.
- Pointer wrap: the free-list rd/wr indices are PTR_WIDTH bits and wrap naturally modulo DEPTH. Fullness and emptiness are decided by free_cnt only.
- Free-list storage: DEPTH x PTR_WIDTH RAM with a registered read, or registers. The popped value must be available for res_o in the following cycle.

Optional Feature:
SM_DOUBLE_FREE_CHECK_EN
- Defined:
  - Keep a DEPTH-bit allocated bitmap.
  - Set the bit on each WR_OK pop; clear it on an accepted free.
  - A free of a pointer whose bit is 0 is dropped (no push, no count change) and sets the sticky output dbl_free_err_o (1 bit, reset 0, cleared only by reset).
  - Same-cycle alloc of ptr X and free of X: the bitmap takes the alloc, so the free is checked against the bit value before that cycle's alloc.
- Undefined:
  - No bitmap and no dbl_free_err_o port.
  - All frees are accepted subject only to the free_cnt==DEPTH drop rule.

Test Plan:
- Release reset, idle -> init_done_o rises exactly DEPTH (256) cycles after release; free_cnt_o=256; no ready or response asserted before that.
- Requester 0 issues 3 back-to-back requests -> responses {WR_OK,0},{WR_OK,1},{WR_OK,2} on consecutive cycles, each 1 cycle after its grant; free_cnt_o=253.
- All 4 requesters held valid -> grants in order 0,1,2,3,0,1; res_valid_o one-hot matches each grant delayed by one cycle.
- Perform 256 allocations, then one more -> 257th gets {WR_ERR_NO_SPACE,0}; then free ptr 5 -> next alloc returns {WR_OK,5}. Free and alloc in the same cycle at count 0 -> alloc gets NO_SPACE, free_cnt_o=1.
- Reset asserted mid-burst of allocations -> all outputs clear immediately; INIT reruns; first post-init alloc returns ptr 0.
- With SM_DOUBLE_FREE_CHECK_EN: allocate ptr 0, free 0, free 0 again -> second free dropped, free_cnt_o unchanged, dbl_free_err_o=1 and stays 1.
